// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable payload width,
// optional even/odd parity, one or two stop bits, and a valid/ready output
// register with a sticky overrun flag.
// Build option: define UART_RX_MAJORITY_EN to decide each bit as the 2-of-3
// majority of the samples one tick before, at, and one tick after mid-bit;
// left undefined, each bit is the single sample taken at mid-bit.
module uart_rx_param #(
  parameter int CLK_HZ      = 5_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE + 1);
  localparam int BIT_W   = 4;
`ifdef UART_RX_MAJORITY_EN
  // Decision is made on the last of the three samples, one tick past mid-bit.
  localparam int START_DEC = OVERSAMPLE / 2 + 1;
`else
  localparam int START_DEC = OVERSAMPLE / 2;
`endif

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
  localparam logic [TICK_W-1:0] START_LAST = TICK_W'(START_DEC - 1);
  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
  localparam logic              PAR_ODD    = (PARITY_MODE == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Even-parity reduction of the received payload.
  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

`ifdef UART_RX_MAJORITY_EN
  // 2-of-3 vote across three neighbouring samples.
  function automatic logic f_majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_rx_meta;
  logic                  r_rx_sync;
  logic                  r_rx_prev;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par_bit;
  logic                  r_stop_err;
  logic [DATA_BITS-1:0]  r_data_out;
  logic                  r_data_valid;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  r_busy;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]            r_samp;
`endif

  logic                  w_tick;
  logic                  w_sample;
  logic                  w_bit;
  logic                  w_done;
  logic                  w_frame_err;
  logic                  w_parity_err;
  logic                  w_load;
  logic                  w_handshake;

  // Two-flop synchronizer on the raw line plus a delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Oversample tick and bit-decision strobe; both are idle outside a frame.
  always_comb begin
    w_tick   = 1'b0;
    w_sample = 1'b0;
    if (r_state != IDLE) begin
      w_tick = (r_div_cnt == DIV_LAST);
      if (r_state == START) begin
        w_sample = w_tick && (r_tick_cnt == START_LAST);
      end else begin
        w_sample = w_tick && (r_tick_cnt == BIT_LAST);
      end
    end else begin
      w_tick   = 1'b0;
      w_sample = 1'b0;
    end
  end

  // Clock divider and tick-within-bit counter, both held at zero in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt  <= {DIV_W{1'b0}};
      r_tick_cnt <= {TICK_W{1'b0}};
    end else if (r_state == IDLE) begin
      r_div_cnt  <= {DIV_W{1'b0}};
      r_tick_cnt <= {TICK_W{1'b0}};
    end else begin
      if (w_tick) begin
        r_div_cnt <= {DIV_W{1'b0}};
      end else begin
        r_div_cnt <= r_div_cnt + DIV_ONE;
      end
      if (w_sample) begin
        r_tick_cnt <= {TICK_W{1'b0}};
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + TICK_ONE;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History of the two most recent tick samples feeding the vote.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_samp <= 2'b11;
    end else if (w_tick) begin
      r_samp <= {r_samp[0], r_rx_sync};
    end
  end

  // Bit value is the vote of the previous two tick samples and the current one.
  always_comb begin
    w_bit = f_majority3(r_samp[1], r_samp[0], r_rx_sync);
  end
`else
  // Bit value is the single synchronized sample at the decision tick.
  always_comb begin
    w_bit = r_rx_sync;
  end
`endif

  // Frame status as it will stand once the current stop sample is folded in.
  always_comb begin
    w_frame_err = r_stop_err | ~w_bit;
    if (PARITY_MODE != 0) begin
      w_parity_err = (f_parity(r_shift) ^ r_par_bit) != PAR_ODD;
    end else begin
      w_parity_err = 1'b0;
    end
  end

  // Next-state decode for the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_sample) begin
          if (w_bit) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_sample && (r_bit_cnt == DATA_LAST)) begin
          if (PARITY_MODE != 0) begin
            w_state_nxt = PARITY;
          end else begin
            w_state_nxt = STOP;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_state_nxt = STOP;
        end else begin
          w_state_nxt = PARITY;
        end
      end
      STOP: begin
        if (w_sample && (r_bit_cnt == STOP_LAST)) begin
          w_done = 1'b1;
          if (w_frame_err) begin
            w_state_nxt = WAIT_HIGH;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      WAIT_HIGH: begin
        if (r_rx_sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_HIGH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame assembly: payload shift (LSB first), parity bit and stop-bit error.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt  <= {BIT_W{1'b0}};
      r_shift    <= {DATA_BITS{1'b0}};
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          r_bit_cnt  <= {BIT_W{1'b0}};
          r_stop_err <= 1'b0;
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= {BIT_W{1'b0}};
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
          end
        end
        PARITY: begin
          if (w_sample) begin
            r_par_bit <= w_bit;
          end
        end
        STOP: begin
          if (w_sample) begin
            r_stop_err <= w_frame_err;
            r_bit_cnt  <= r_bit_cnt + BIT_ONE;
          end
        end
        default: begin
          r_bit_cnt <= r_bit_cnt;
        end
      endcase
    end
  end

  // Output register: load on completion when free or being drained, else flag overrun.
  always_comb begin
    w_handshake = r_data_valid && data_ready;
    w_load      = w_done && (!r_data_valid || data_ready);
  end

  // Holding register, handshake and sticky overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out   <= {DATA_BITS{1'b0}};
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_load) begin
        r_data_out   <= r_shift;
        r_parity_err <= w_parity_err;
        r_frame_err  <= w_frame_err;
        r_data_valid <= 1'b1;
      end else if (w_handshake) begin
        r_data_valid <= 1'b0;
      end
      if (w_handshake) begin
        r_overrun <= 1'b0;
      end else if (w_done && r_data_valid) begin
        r_overrun <= 1'b1;
      end
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed scenarios on a default 8N1 instance
// (512-clock bit period) and randomized frames on a fast 8E2 instance,
// checked against an arithmetic frame model.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int A_BIT = 512;
  localparam int B_BIT = 64;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       a_rx, a_ready, a_valid, a_pe, a_fe, a_ovr, a_busy;
  logic [7:0] a_data;
  logic       b_rx, b_ready, b_valid, b_pe, b_fe, b_ovr, b_busy;
  logic [7:0] b_data;

  // Log of accepted frames {frame_err, parity_err, data} and activity counters.
  logic [9:0] a_log [0:63];
  logic [9:0] b_log [0:63];
  int a_n = 0, b_n = 0;
  int a_hi = 0, a_busy_lo = 0, a_rise_cyc = 0;
  logic a_valid_d = 1'b0;

  always #5 clock = ~clock;

  // Free-running cycle count.
  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_param u_dut_a (
    .clock(clock), .reset(reset), .rx(a_rx),
    .data_out(a_data), .data_valid(a_valid), .data_ready(a_ready),
    .parity_err(a_pe), .frame_err(a_fe), .overrun(a_ovr), .busy(a_busy)
  );

  uart_rx_param #(
    .CLK_HZ(5_000_000), .BAUD(78125), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)
  ) u_dut_b (
    .clock(clock), .reset(reset), .rx(b_rx),
    .data_out(b_data), .data_valid(b_valid), .data_ready(b_ready),
    .parity_err(b_pe), .frame_err(b_fe), .overrun(b_ovr), .busy(b_busy)
  );

  // Monitor: record every handshake and count valid-high / busy-low cycles.
  always @(negedge clock) begin
    if (a_valid && a_ready && a_n < 64) begin
      a_log[a_n] <= {a_fe, a_pe, a_data};
      a_n <= a_n + 1;
    end
    if (b_valid && b_ready && b_n < 64) begin
      b_log[b_n] <= {b_fe, b_pe, b_data};
      b_n <= b_n + 1;
    end
    if (a_valid) a_hi <= a_hi + 1;
    if (!a_busy) a_busy_lo <= a_busy_lo + 1;
    if (a_valid && !a_valid_d) a_rise_cyc <= cyc;
    a_valid_d <= a_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic v, input int per);
    if (which == 0) a_rx = v; else b_rx = v;
    repeat (per) @(negedge clock);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                            input logic pb, input int nstop, input logic s1, input logic s2);
    int per;
    per = (which == 0) ? A_BIT : B_BIT;
    drive_bit(which, 1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], per);
    if (has_par) drive_bit(which, pb, per);
    drive_bit(which, s1, per);
    if (nstop == 2) drive_bit(which, s2, per);
  endtask

  // Reference: even parity error when payload ones plus parity bit is odd;
  // framing error when any stop bit is low.
  function automatic logic [9:0] model_frame(input logic [7:0] d, input logic pb,
                                             input logic s1, input logic s2);
    logic pe, fe;
    pe = ((($countones(d) + int'(pb)) % 2) != 0);
    fe = (s1 == 1'b0) || (s2 == 1'b0);
    return {fe, pe, d};
  endfunction

  // Compare the next logged frame of a DUT against an expected record.
  task automatic check_next(input string tag, input int which, inout int rd, input logic [9:0] exp);
    int n;
    logic [9:0] e;
    n = (which == 0) ? a_n : b_n;
    check_eq({tag, "_count"}, n - rd, 1);
    if (n > rd) begin
      e = (which == 0) ? a_log[rd] : b_log[rd];
      check_eq({tag, "_data"}, {24'd0, e[7:0]}, {24'd0, exp[7:0]});
      check_eq({tag, "_perr"}, {31'd0, e[8]}, {31'd0, exp[8]});
      check_eq({tag, "_ferr"}, {31'd0, e[9]}, {31'd0, exp[9]});
      rd = n;
    end
  endtask

  initial begin
    int rd, hi0, bl0, t0, lat;
    logic [7:0] d;
    logic pb, s1, s2;

    reset = 1'b1; a_rx = 1'b1; b_rx = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    repeat (5) @(negedge clock);
    check_eq("rst_data",  {24'd0, a_data}, 32'd0);
    check_eq("rst_valid", {31'd0, a_valid}, 32'd0);
    check_eq("rst_perr",  {31'd0, a_pe}, 32'd0);
    check_eq("rst_ferr",  {31'd0, a_fe}, 32'd0);
    check_eq("rst_ovr",   {31'd0, a_ovr}, 32'd0);
    check_eq("rst_busy",  {31'd0, a_busy}, 32'd0);
    check_eq("rst_b_valid", {31'd0, b_valid}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    // 0xA5 8N1 with consumer ready: single-cycle valid pulse, clean flags.
    rd = a_n; hi0 = a_hi; t0 = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 100);
    check_next("a5", 0, rd, {2'b00, 8'hA5});
    check_eq("a5_pulse_len", a_hi - hi0, 1);
    lat = a_rise_cyc - t0;
    check_eq("a5_latency_window", {31'd0, (lat >= 4860 && lat <= 4905)}, 32'd1);

    // 0x3C with low stop bit and line held low: framing error, busy held.
    rd = a_n;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    bl0 = a_busy_lo;
    drive_bit(0, 1'b0, 2000);
    check_eq("3c_busy_held", {31'd0, a_busy}, 32'd1);
    check_eq("3c_busy_low_cycles", a_busy_lo - bl0, 0);
    check_next("3c", 0, rd, {2'b10, 8'h3C});
    a_rx = 1'b1;
    for (int i = 0; i < 20 && a_busy; i++) @(negedge clock);
    check_eq("3c_busy_release", {31'd0, a_busy}, 32'd0);
    drive_bit(0, 1'b1, 100);

    // Back-to-back 0x11, 0x22 with no consumer: first kept, overrun set.
    a_ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 100);
    check_eq("ovr_valid", {31'd0, a_valid}, 32'd1);
    check_eq("ovr_data",  {24'd0, a_data}, 32'h11);
    check_eq("ovr_flag",  {31'd0, a_ovr}, 32'd1);
    check_eq("ovr_ferr",  {31'd0, a_fe}, 32'd0);
    a_ready = 1'b1;
    @(negedge clock);
    a_ready = 1'b0;
    @(negedge clock);
    check_eq("ovr_valid_clr", {31'd0, a_valid}, 32'd0);
    check_eq("ovr_flag_clr",  {31'd0, a_ovr}, 32'd0);
    a_ready = 1'b1;
    drive_bit(0, 1'b1, 20);

    // Glitch: 100-clock low pulse is a false start.
    rd = a_n; hi0 = a_hi;
    drive_bit(0, 1'b0, 100);
    a_rx = 1'b1;
    for (int i = 0; i < 300 && a_busy; i++) @(negedge clock);
    check_eq("glitch_busy", {31'd0, a_busy}, 32'd0);
    drive_bit(0, 1'b1, 50);
    check_eq("glitch_no_frame", a_n - rd, 0);
    check_eq("glitch_no_valid", a_hi - hi0, 0);

    // Reset in the middle of 0x55 data bits, then a clean 0x81.
    rd = a_n;
    drive_bit(0, 1'b0, A_BIT);
    drive_bit(0, 1'b1, A_BIT);
    drive_bit(0, 1'b0, A_BIT);
    drive_bit(0, 1'b1, 256);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("midrst_busy", {31'd0, a_busy}, 32'd0);
    reset = 1'b0;
    drive_bit(0, 1'b1, 1000);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    drive_bit(0, 1'b1, 100);
    check_next("midrst_81", 0, rd, {2'b00, 8'h81});
    check_eq("midrst_ovr", {31'd0, a_ovr}, 32'd0);

    // Even parity: 0x07 with wrong then right parity bit.
    rd = b_n;
    send_frame(1, 8'h07, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    drive_bit(1, 1'b1, 20);
    check_next("par07_p0", 1, rd, {2'b01, 8'h07});
    send_frame(1, 8'h07, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    drive_bit(1, 1'b1, 20);
    check_next("par07_p1", 1, rd, {2'b00, 8'h07});

    // Randomized frames against the reference model.
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      send_frame(1, d, 1'b1, pb, 2, s1, s2);
      drive_bit(1, 1'b1, $urandom_range(4, 40));
      check_next("rnd", 1, rd, model_frame(d, pb, s1, s2));
    end
    check_eq("rnd_ovr", {31'd0, b_ovr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
